// File: rtl/pll_rst_seq.sv
// Reset/lock sequencer: pulses the PLL reset, qualifies lock, then releases sys_rst.
// Optional lock-loss counter enabled by defining LOCK_LOSS_CNT_EN.
module pll_rst_seq #(
  parameter int SYNC_STAGES      = 2,
  parameter int PLL_RST_CYC      = 16,
  parameter int LOCK_TIMEOUT_CYC = 50000,
  parameter int STABLE_CYC       = 1024,
  parameter int HOLD_CYC         = 256,
  parameter int CNT_W            = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_locked,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             sys_ready,
  output logic [CNT_W-1:0] lock_loss_cnt
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int TMR_MAX = max2(max2(PLL_RST_CYC, LOCK_TIMEOUT_CYC),
                                max2(STABLE_CYC, HOLD_CYC));
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] PLL_RST_LAST = TMR_W'(PLL_RST_CYC - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(STABLE_CYC - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST    = TMR_W'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    HOLD      = 3'd3,
    RUN       = 3'd4
  } state_t;

  state_t                 state;
  logic [TMR_W-1:0]       timer;
  logic [SYNC_STAGES-1:0] locked_sync;
  logic                   locked_s;

  assign locked_s = locked_sync[SYNC_STAGES-1];

  // pll_locked crossing into the board clock domain
  always_ff @(posedge clk) begin
    if (rst) begin
      locked_sync <= '0;
    end else begin
      locked_sync <= {locked_sync[SYNC_STAGES-2:0], pll_locked};
    end
  end

  // Sequencer: the timer is cleared on every state change and held at 0 in RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PLL_RST;
      timer     <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      sys_ready <= 1'b0;
    end else begin
      timer <= timer + TMR_W'(1);
      case (state)
        PLL_RST: begin
          if (timer == PLL_RST_LAST) begin
            state   <= WAIT_LOCK;
            timer   <= '0;
            pll_rst <= 1'b0;
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state <= STABLE;
            timer <= '0;
          end else if (timer == TIMEOUT_LAST) begin
            state   <= PLL_RST;
            timer   <= '0;
            pll_rst <= 1'b1;
          end
        end
        STABLE: begin
          if (!locked_s) begin
            state <= WAIT_LOCK;
            timer <= '0;
          end else if (timer == STABLE_LAST) begin
            state <= HOLD;
            timer <= '0;
          end
        end
        HOLD: begin
          if (!locked_s) begin
            state <= WAIT_LOCK;
            timer <= '0;
          end else if (timer == HOLD_LAST) begin
            state     <= RUN;
            timer     <= '0;
            sys_rst   <= 1'b0;
            sys_ready <= 1'b1;
          end
        end
        RUN: begin
          timer <= '0;
          if (!locked_s) begin
            state     <= WAIT_LOCK;
            sys_rst   <= 1'b1;
            sys_ready <= 1'b0;
          end
        end
        default: begin
          state     <= PLL_RST;
          timer     <= '0;
          pll_rst   <= 1'b1;
          sys_rst   <= 1'b1;
          sys_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef LOCK_LOSS_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  logic lock_loss_ev;
  assign lock_loss_ev = (state == RUN) && !locked_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_loss_cnt <= '0;
    end else if (lock_loss_ev) begin
      lock_loss_cnt <= sat_inc(lock_loss_cnt);
    end
  end
`else
  assign lock_loss_cnt = '0;
`endif

endmodule
